// File: rtl/lsu_writeback_if.sv
// Execute/memory/register-file bundle for lsu_writeback.
// The slave modport is the LSU's view; master is the surrounding pipeline and memory.
interface lsu_writeback_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [ADDR_WIDTH-1:0] req_rd;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [31:0]           mem_addr;
  logic                  mem_wen;
  logic [3:0]            mem_wmask;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  done;
  logic                  fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    input  rf_wen, rf_waddr, rf_wdata, done, fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    output rf_wen, rf_waddr, rf_wdata, done, fault
  );
endinterface

// File: rtl/lsu_writeback.sv
// Multi-cycle RV32 load/store unit: memory request, load align/extend, register-file writeback.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of lane rounding.
module lsu_writeback #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  lsu_writeback_if.slave   bus
);

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {StIdle, StReq, StWait, StWb, StFault} state_e;
`else
  typedef enum logic [2:0] {StIdle, StReq, StWait, StWb} state_e;
`endif

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  // Unlisted funct3 encodings fall through to word access.
  function automatic logic [1:0] op_size(input logic we, input logic [2:0] f3);
    logic [1:0] sz;
    sz = SzWord;
    if (we) begin
      if (f3 == 3'b000)      sz = SzByte;
      else if (f3 == 3'b001) sz = SzHalf;
    end else begin
      if (f3 == 3'b000 || f3 == 3'b100)      sz = SzByte;
      else if (f3 == 3'b001 || f3 == 3'b101) sz = SzHalf;
    end
    return sz;
  endfunction

  state_e                state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic                  accept;
  logic [1:0]            size;
  logic [DATA_WIDTH-1:0] ld_shift_b, ld_shift_h, ld_ext;
  logic [3:0]            st_mask;
  logic [DATA_WIDTH-1:0] st_data;

  assign accept = (state_q == StIdle) && bus.req_valid;
  assign size   = op_size(we_q, funct3_q);

`ifdef LSU_MISALIGN_TRAP_EN
  logic [1:0] req_size;
  logic       req_misaligned;
  assign req_size       = op_size(bus.req_we, bus.req_funct3);
  assign req_misaligned = ((req_size == SzHalf) && bus.req_addr[0]) ||
                          ((req_size == SzWord) && (bus.req_addr[1:0] != 2'b00));
`endif

  assign ld_shift_b = bus.mem_rdata >> {addr_q[1:0], 3'b000};
  assign ld_shift_h = bus.mem_rdata >> {addr_q[1], 4'b0000};

  always_comb begin
    ld_ext  = bus.mem_rdata;
    st_mask = 4'b1111;
    st_data = wdata_q;
    unique case (size)
      SzByte: begin
        ld_ext  = funct3_q[2] ? {24'b0, ld_shift_b[7:0]} : {{24{ld_shift_b[7]}}, ld_shift_b[7:0]};
        st_mask = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      SzHalf: begin
        ld_ext  = funct3_q[2] ? {16'b0, ld_shift_h[15:0]} :
                                {{16{ld_shift_h[15]}}, ld_shift_h[15:0]};
        st_mask = 4'b0011 << {addr_q[1], 1'b0};
        st_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    rf_waddr_d        = rf_waddr_q;
    rf_wdata_d        = rf_wdata_q;
    bus.req_ready     = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wen       = 1'b0;
    bus.mem_wmask     = '0;
    bus.mem_wdata     = '0;
    bus.rf_wen        = 1'b0;
    bus.done          = 1'b0;
    bus.fault         = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = !rst;
        if (bus.req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          state_d = req_misaligned ? StFault : StReq;
`else
          state_d = StReq;
`endif
        end
      end
      StReq: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = {addr_q[31:2], 2'b00};
        bus.mem_wen       = we_q;
        bus.mem_wmask     = we_q ? st_mask : 4'b0000;
        bus.mem_wdata     = we_q ? st_data : '0;
        if (bus.mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (bus.mem_resp_valid) begin
          if (we_q) begin
            bus.done = 1'b1;
            state_d  = StIdle;
          end else begin
            rf_waddr_d = rd_q;
            rf_wdata_d = ld_ext;
            state_d    = StWb;
          end
        end
      end
      StWb: begin
        bus.rf_wen = (rd_q != '0);
        bus.done   = 1'b1;
        state_d    = StIdle;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      StFault: begin
        bus.fault = 1'b1;
        bus.done  = 1'b1;
        state_d   = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      if (accept) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        rd_q     <= bus.req_rd;
      end
    end
  end

endmodule

// File: tb/tb_lsu_writeback.sv
// Randomized bench for lsu_writeback against an arithmetic model of the load/store rules.
// Follows LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_lsu_writeback;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_writeback_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus_if ();

  lsu_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  logic [4:0]  last_waddr;
  logic [31:0] last_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned op_bytes(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic is_misaligned(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (addr % op_bytes(we, f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] load_result(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
    logic [31:0] v;
    int unsigned n;
    n = op_bytes(1'b0, f3);
    if (n == 1) begin
      v = (rdata >> (8 * (addr % 4))) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (n == 2) begin
      v = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_mask(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned n;
    n = op_bytes(1'b1, f3);
    if (n == 1) return 32'd1 << (addr % 4);
    if (n == 2) return 32'd3 << (2 * ((addr / 2) % 2));
    return 32'd15;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    int unsigned n;
    n = op_bytes(1'b1, f3);
    if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_mreqv"}, bus_if.mem_req_valid, 0);
    check({tag, "_maddr"}, bus_if.mem_addr, 0);
    check({tag, "_mwen"},  bus_if.mem_wen, 0);
    check({tag, "_mmask"}, bus_if.mem_wmask, 0);
    check({tag, "_mwdata"}, bus_if.mem_wdata, 0);
    check({tag, "_rfwen"}, bus_if.rf_wen, 0);
    check({tag, "_done"},  bus_if.done, 0);
    check({tag, "_fault"}, bus_if.fault, 0);
  endtask

  // Entered shortly after a negedge with the DUT idle; returns in the same phase.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int stall, input int delay);
    logic [31:0] exp_ld;
    check("idle_ready", bus_if.req_ready, 1);
    check_all_zero("idle");
    bus_if.req_valid  = 1'b1;
    bus_if.req_we     = we;
    bus_if.req_funct3 = f3;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wd;
    bus_if.req_rd     = rd;
    @(negedge clk);
    bus_if.req_valid  = 1'b0;
    bus_if.req_we     = 1'($urandom);
    bus_if.req_funct3 = 3'($urandom);
    bus_if.req_addr   = $urandom;
    bus_if.req_wdata  = $urandom;
    bus_if.req_rd     = 5'($urandom);
    #1;
    check("busy_ready", bus_if.req_ready, 0);
    if (is_misaligned(we, f3, addr)) begin
      check("trap_fault", bus_if.fault, 1);
      check("trap_done", bus_if.done, 1);
      check("trap_mreqv", bus_if.mem_req_valid, 0);
      check("trap_rfwen", bus_if.rf_wen, 0);
      @(negedge clk);
      #1;
      check("trap_end_fault", bus_if.fault, 0);
      check("trap_end_ready", bus_if.req_ready, 1);
      return;
    end
    check("req_fault", bus_if.fault, 0);
    for (int s = 0; s <= stall; s++) begin
      bus_if.mem_req_ready  = (s == stall);
      bus_if.mem_resp_valid = (s == stall) ? 1'b0 : 1'($urandom);
      bus_if.mem_rdata      = $urandom;
      #1;
      check("req_valid", bus_if.mem_req_valid, 1);
      check("req_addr", bus_if.mem_addr, addr & 32'hFFFF_FFFC);
      check("req_wen", bus_if.mem_wen, we);
      check("req_mask", bus_if.mem_wmask, we ? store_mask(f3, addr) : 0);
      check("req_wdata", bus_if.mem_wdata, we ? store_data(f3, wd) : 0);
      check("req_ready0", bus_if.req_ready, 0);
      check("req_done", bus_if.done, 0);
      @(negedge clk);
    end
    bus_if.mem_req_ready  = 1'b0;
    bus_if.mem_resp_valid = 1'b0;
    for (int d = 0; d < delay; d++) begin
      #1;
      check("wait_mreqv", bus_if.mem_req_valid, 0);
      check("wait_maddr", bus_if.mem_addr, 0);
      check("wait_done", bus_if.done, 0);
      @(negedge clk);
    end
    bus_if.mem_resp_valid = 1'b1;
    bus_if.mem_rdata      = rdata;
    #1;
    check("resp_done", bus_if.done, we);
    check("resp_rfwen", bus_if.rf_wen, 0);
    @(negedge clk);
    bus_if.mem_resp_valid = 1'b0;
    bus_if.mem_rdata      = $urandom;
    #1;
    if (!we) begin
      exp_ld = load_result(f3, addr, rdata);
      check("wb_rfwen", bus_if.rf_wen, rd != 0);
      check("wb_waddr", bus_if.rf_waddr, rd);
      check("wb_wdata", bus_if.rf_wdata, exp_ld);
      check("wb_done", bus_if.done, 1);
      check("wb_mreqv", bus_if.mem_req_valid, 0);
      last_waddr = rd;
      last_wdata = exp_ld;
      @(negedge clk);
      #1;
    end
    check("end_done", bus_if.done, 0);
    check("end_rfwen", bus_if.rf_wen, 0);
    check("end_ready", bus_if.req_ready, 1);
    check("end_waddr", bus_if.rf_waddr, last_waddr);
    check("end_wdata", bus_if.rf_wdata, last_wdata);
  endtask

  initial begin
    rst                   = 1'b1;
    bus_if.req_valid      = 1'b0;
    bus_if.req_we         = 1'b0;
    bus_if.req_funct3     = 3'd0;
    bus_if.req_addr       = 32'd0;
    bus_if.req_wdata      = 32'd0;
    bus_if.req_rd         = 5'd0;
    bus_if.mem_req_ready  = 1'b0;
    bus_if.mem_resp_valid = 1'b0;
    bus_if.mem_rdata      = 32'd0;
    last_waddr            = 5'd0;
    last_wdata            = 32'd0;
    #1;
    check_all_zero("rst");
    check("rst_waddr", bus_if.rf_waddr, 0);
    check("rst_wdata", bus_if.rf_wdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", bus_if.req_ready, 1);

    run_op(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd5, 32'h80FF_1234, 0, 0);
    run_op(1'b0, 3'b101, 32'h0000_1002, 32'h0, 5'd7, 32'hBEEF_0000, 0, 1);
    run_op(1'b0, 3'b001, 32'h0000_1002, 32'h0, 5'd8, 32'hBEEF_0000, 1, 0);
    run_op(1'b1, 3'b000, 32'h0000_2001, 32'h1234_56AB, 5'd3, 32'h0, 0, 0);
    run_op(1'b1, 3'b001, 32'h0000_2002, 32'hCAFE_F00D, 5'd0, 32'h0, 2, 1);
    run_op(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd0, 32'h1357_9BDF, 5, 0);
    run_op(1'b0, 3'b010, 32'h0000_4002, 32'h0, 5'd9, 32'hA5A5_0F0F, 0, 0);
    run_op(1'b1, 3'b010, 32'h0000_4003, 32'hDEAD_BEEF, 5'd0, 32'h0, 0, 0);

    // Reset while waiting for the response; the late response must be dropped.
    bus_if.req_valid  = 1'b1;
    bus_if.req_we     = 1'b0;
    bus_if.req_funct3 = 3'b010;
    bus_if.req_addr   = 32'h0000_5000;
    bus_if.req_rd     = 5'd12;
    @(negedge clk);
    bus_if.req_valid     = 1'b0;
    bus_if.mem_req_ready = 1'b1;
    @(negedge clk);
    bus_if.mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    check("midrst_ready", bus_if.req_ready, 0);
    check("midrst_waddr", bus_if.rf_waddr, 0);
    check("midrst_wdata", bus_if.rf_wdata, 0);
    bus_if.mem_resp_valid = 1'b1;
    bus_if.mem_rdata      = 32'h7777_7777;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("late_rfwen", bus_if.rf_wen, 0);
    check("late_done", bus_if.done, 0);
    check("late_wdata", bus_if.rf_wdata, 0);
    bus_if.mem_resp_valid = 1'b0;
    last_waddr = 5'd0;
    last_wdata = 32'd0;
    run_op(1'b0, 3'b100, 32'h0000_6002, 32'h0, 5'd31, 32'h00C3_0000, 0, 0);

    for (int i = 0; i < 300; i++) begin
      run_op(1'($urandom), 3'($urandom), $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
